// File: rtl/alu_rs.sv
// Single-ALU reservation station: holds dispatched ops until both sources are ready, issues one per cycle.
// Optional ALU_RS_RESULT_BYPASS_EN: the local result register also wakes waiting sources (CDB wins ties).
module alu_rs #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [3:0]       disp_func,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic             disp_src1_rdy,
    input  logic [TAG_W-1:0] disp_src1_tag,
    input  logic [WIDTH-1:0] disp_src1_val,
    input  logic             disp_src2_rdy,
    input  logic [TAG_W-1:0] disp_src2_tag,
    input  logic [WIDTH-1:0] disp_src2_val,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [WIDTH-1:0] cdb_data,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [3:0]       alu_func,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic [WIDTH-1:0] res_data
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef struct packed {
        logic             rdy;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] val;
    } src_t;

    typedef struct packed {
        logic             vld;
        logic [3:0]       func;
        logic [TAG_W-1:0] dst;
        src_t             s1;
        src_t             s2;
    } ent_t;

    ent_t             ent [ENTRIES];
    logic             iss_valid;
    logic [TAG_W-1:0] iss_tag;
    logic [IDX_W-1:0] free_idx, sel_idx;
    logic             free_any, sel_any;
    src_t             d1, d2;

    assign d1 = '{rdy: disp_src1_rdy, tag: disp_src1_tag, val: disp_src1_val};
    assign d2 = '{rdy: disp_src2_rdy, tag: disp_src2_tag, val: disp_src2_val};

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        free_idx = '0;
        free_any = 1'b0;
        sel_idx  = '0;
        sel_any  = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!ent[i].vld) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (ent[i].vld && ent[i].s1.rdy && ent[i].s2.rdy) begin
                sel_any = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign disp_ready = free_any;

    function automatic src_t wake(input src_t s);
        wake = s;
        if (!s.rdy) begin
            if (cdb_valid && cdb_tag == s.tag) begin
                wake.rdy = 1'b1;
                wake.val = cdb_data;
            end
`ifdef ALU_RS_RESULT_BYPASS_EN
            else if (res_valid && res_tag == s.tag) begin
                wake.rdy = 1'b1;
                wake.val = res_data;
            end
`endif
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
            alu_op1   <= '0;
            alu_op2   <= '0;
            alu_func  <= '0;
            iss_valid <= 1'b0;
            iss_tag   <= '0;
            res_valid <= 1'b0;
            res_tag   <= '0;
            res_data  <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (ent[i].vld) begin
                    ent[i].s1 <= wake(ent[i].s1);
                    ent[i].s2 <= wake(ent[i].s2);
                end
            end
            iss_valid <= sel_any;
            if (sel_any) begin
                ent[sel_idx].vld <= 1'b0;
                alu_op1          <= ent[sel_idx].s1.val;
                alu_op2          <= ent[sel_idx].s2.val;
                alu_func         <= ent[sel_idx].func;
                iss_tag          <= ent[sel_idx].dst;
            end
            // Target slot is invalid, so it never collides with wakeup or select writes.
            if (disp_valid && free_any)
                ent[free_idx] <= '{vld: 1'b1, func: disp_func, dst: disp_tag,
                                   s1: wake(d1), s2: wake(d2)};
            res_valid <= iss_valid;
            if (iss_valid) begin
                res_tag  <= iss_tag;
                res_data <= alu_out;
            end
        end
    end
endmodule
